bus_ctrl_multi: RTL
===================

Name: bus_ctrl_multi

Overview:
Parametrised 68000-style bus controller for the SCC68070 side of the system. It replaces ad-hoc chip-select, DTACK and bus-error glue with one registered block. The block decodes up to NUM_REGIONS address windows and generates per-region chip selects. It times each access with programmable wait states or an external device acknowledge, muxes and registers read data, and raises bus_err for unmapped addresses or timeouts. It sits between the CPU core and the peripheral slaves (video, CD interface, slave MCU, NVRAM).

Parameters:
NUM_REGIONS, 4, number of decoded windows; 1..8.
WS_W, 4, width of each per-region wait-state count.
TIMEOUT, 255, WAIT-state cycles before bus_err; 2..65535.
ERRCNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
as  in  1  CPU address strobe
uds  in  1  upper data strobe
lds  in  1  lower data strobe
write_strobe  in  1  1 = write cycle
addr  in  23  CPU word address addr[23:1]
region_base  in  8*NUM_REGIONS  per-region match value for addr[23:16]; static
region_mask  in  8*NUM_REGIONS  per-region compare mask for addr[23:16]; static
region_ws  in  WS_W*NUM_REGIONS  per-region wait states; static
region_ext  in  NUM_REGIONS  1 = region waits for dev_ack instead of region_ws
dev_ack  in  NUM_REGIONS  per-device acknowledge; level, sampled only in WAIT
dev_dout  in  16*NUM_REGIONS  per-device read data
cs  out  NUM_REGIONS  one-hot chip select, registered
bus_ack  out  1  DTACK to CPU, one-cycle pulse
bus_err  out  1  BERR to CPU, one-cycle pulse
data_in  out  16  registered read data to CPU
err_count  out  ERRCNT_W  saturating count of bus errors
last_err_addr  out  23  addr of the most recent bus error

Behaviour:
- Reset: state IDLE. cs, bus_ack, bus_err, data_in, err_count and last_err_addr are all 0. Reset mid-access aborts the access without an ack or an error.
- Request condition: req = as && (uds || lds).
- Region match: match[i] = ((addr[23:16] ^ base_i) & mask_i) == 0. The lowest matching index wins; overlapping windows are legal.
- FSM states: IDLE, WAIT, ACK, ERR, DONE.
- IDLE:
  - On a clock edge with req and a match: latch the region index, load wcnt = region_ws[idx], clear tcnt, set cs[idx], go to WAIT.
  - On req with no match: go to ERR.
- WAIT:
  - If !as: abort to IDLE, clear cs, no pulse.
  - Internal mode (region_ext=0): if wcnt != 0, decrement; if wcnt == 0, go to ACK.
  - External mode: when dev_ack[idx] = 1, go to ACK.
  - tcnt increments every WAIT cycle. If tcnt reaches TIMEOUT-1 and the ACK condition is not met, go to ERR. If the ACK condition and the timeout occur on the same edge, ACK wins.
  - On the transition to ACK: capture data_in <= dev_dout[idx] for read cycles; data_in holds its value on write cycles.
- Latency (internal mode): request sampled at edge 0. bus_ack is high for the single cycle after edge region_ws+1. Example: ws=0 gives ack after edge 1; ws=3 gives ack after edge 4.
- ACK: bus_ack=1 for exactly one cycle, cs held, then go to DONE.
- ERR:
  - bus_err=1 for exactly one cycle and cs is cleared.
  - last_err_addr <= addr.
  - err_count increments and saturates at all-ones.
  - Then go to DONE.
- DONE: cs cleared. Return to IDLE when !as. No new access starts while as stays high, so a held strobe never produces a second ack.
- At most one of bus_ack and bus_err is high in any cycle; both are 0 outside ACK and ERR.
- write_strobe does not affect timing. It only gates the data_in capture.

Test Plan:
- Region0 base=0x00 mask=0xC0 ws=2, read addr 0x010000 with dev_dout0=0x1234 -> cs=0001 after edge 0; bus_ack pulse after edge 3; data_in=0x1234; err_count=0.
- Region1 base=0x30 mask=0xFF ext=1, dev_ack1 raised 5 cycles after request -> single bus_ack one cycle after the dev_ack sample; no bus_err.
- Access to 0x600000 with no window matching -> bus_err pulse after edge 1; last_err_addr=0x300000 (word address); err_count=1; cs stays 0.
- External region with dev_ack never asserted, TIMEOUT=16 -> bus_err after 16 WAIT cycles; cs drops; dev_ack raised on the timeout edge -> bus_ack instead.
- Region0 mask=0x00 and region2 base=0x32 mask=0xFF both matching 0x320000 -> cs=0001 (priority); as dropped during WAIT -> IDLE, no pulses; reset mid-WAIT -> all outputs 0.
- 300 unmapped accesses with ERRCNT_W=8 -> err_count saturates at 255; as held high after ack -> no second ack until as deasserts.

Source files
------------

// File: rtl/bus_ctrl_multi.sv
// 68000-style bus controller: window decode, chip selects, wait-state or
// device-acknowledge timing, read-data capture and bus-error reporting.
module bus_ctrl_multi #(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned WS_W        = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          as,
    input  logic                          uds,
    input  logic                          lds,
    input  logic                          write_strobe,
    input  logic [23:1]                   addr,
    input  logic [8*NUM_REGIONS-1:0]      region_base,
    input  logic [8*NUM_REGIONS-1:0]      region_mask,
    input  logic [WS_W*NUM_REGIONS-1:0]   region_ws,
    input  logic [NUM_REGIONS-1:0]        region_ext,
    input  logic [NUM_REGIONS-1:0]        dev_ack,
    input  logic [16*NUM_REGIONS-1:0]     dev_dout,
    output logic [NUM_REGIONS-1:0]        cs,
    output logic                          bus_ack,
    output logic                          bus_err,
    output logic [15:0]                   data_in,
    output logic [ERRCNT_W-1:0]           err_count,
    output logic [23:1]                   last_err_addr
);

    localparam int unsigned IDX_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned TCNT_W = 16;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WS_W-1:0]        wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic                   bus_ack_q, bus_ack_d;
    logic                   bus_err_q, bus_err_d;
    logic [15:0]            data_in_q, data_in_d;
    logic [ERRCNT_W-1:0]    err_count_q, err_count_d;
    logic [23:1]            last_err_addr_q, last_err_addr_d;

    logic                   req;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   sel_ext;
    logic [15:0]            sel_dout;
    logic                   ack_cond;

    assign req = as && (uds || lds);

    // Window decode: lowest-index match wins, so scan from the top down
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (((addr[23:16] ^ region_base[8*i +: 8]) & region_mask[8*i +: 8]) == 8'h00) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Per-access selections for the latched region
    always_comb begin
        sel_ext  = region_ext[idx_q];
        sel_dout = dev_dout[32'(idx_q)*16 +: 16];
        ack_cond = sel_ext ? dev_ack[idx_q] : (wcnt_q == '0);
    end

    // Access sequencing and next values of every register
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wcnt_d          = wcnt_q;
        tcnt_d          = tcnt_q;
        cs_d            = cs_q;
        bus_ack_d       = 1'b0;
        bus_err_d       = 1'b0;
        data_in_d       = data_in_q;
        err_count_d     = err_count_q;
        last_err_addr_d = last_err_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        wcnt_d  = region_ws[32'(hit_idx)*WS_W +: WS_W];
                        tcnt_d  = '0;
                        cs_d    = NUM_REGIONS'(1) << hit_idx;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (!as) begin
                    cs_d    = '0;
                    state_d = S_IDLE;
                end else if (ack_cond) begin
                    // Acknowledge beats a timeout landing on the same edge
                    bus_ack_d = 1'b1;
                    if (!write_strobe) begin
                        data_in_d = sel_dout;
                    end
                    state_d = S_ACK;
                end else if (tcnt_q == TCNT_LAST) begin
                    cs_d    = '0;
                    state_d = S_ERR;
                end else if (!sel_ext) begin
                    wcnt_d = wcnt_q - WS_W'(1);
                end
            end
            S_ACK: begin
                cs_d    = '0;
                state_d = S_DONE;
            end
            S_ERR: begin
                cs_d            = '0;
                bus_err_d       = 1'b1;
                last_err_addr_d = addr;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERRCNT_W'(1);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                // Hold here until the strobe drops so one strobe yields one cycle
                cs_d = '0;
                if (!as) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cs_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            wcnt_q          <= '0;
            tcnt_q          <= '0;
            cs_q            <= '0;
            bus_ack_q       <= 1'b0;
            bus_err_q       <= 1'b0;
            data_in_q       <= '0;
            err_count_q     <= '0;
            last_err_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            wcnt_q          <= wcnt_d;
            tcnt_q          <= tcnt_d;
            cs_q            <= cs_d;
            bus_ack_q       <= bus_ack_d;
            bus_err_q       <= bus_err_d;
            data_in_q       <= data_in_d;
            err_count_q     <= err_count_d;
            last_err_addr_q <= last_err_addr_d;
        end
    end

    assign cs            = cs_q;
    assign bus_ack       = bus_ack_q;
    assign bus_err       = bus_err_q;
    assign data_in       = data_in_q;
    assign err_count     = err_count_q;
    assign last_err_addr = last_err_addr_q;

endmodule
